bus_burst_responder: RTL and testbench

- Bus-target (responder) end of the burst bus driven by the DMA controller inside the ramDmaCi custom instruction.
- Decodes a fixed address window and serves single and burst reads and writes from an internal word memory, with programmable wait states.
- Used as the far-end model/peripheral when exercising DMA transfers in simulation.
- Also synthesizable as a small on-chip scratch target.

---
 rtl/bus_burst_responder.sv | 165 ++++++++++++++++
 tb/tb_bus_burst_responder.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_burst_responder.sv
// Burst-bus target: decodes a fixed address window and serves single/burst reads and writes
// from an internal word memory. Optional macro BUS_RESPONDER_STALL_EN adds periodic write stalls.
module bus_burst_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        begin_transaction_in,
  input  logic        end_transaction_in,
  input  logic        read_n_write_in,
  input  logic [31:0] address_data_in,
  input  logic [7:0]  burst_size_in,
  input  logic [3:0]  byte_enables_in,
  input  logic        data_valid_in,
  input  logic        busy_in,
  output logic [31:0] address_data_out,
  output logic        data_valid_out,
  output logic        end_transaction_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int SUMW  = ADDR_BITS + 9;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST, ERR} state_t;

  state_t               state;
  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] addr_next;
  logic [ADDR_BITS-1:0] offset;
  logic [8:0]           words_left;
  logic [3:0]           wait_cnt;
  logic                 wr_err_done;
  logic                 hit;
  logic                 overrun;
  logic                 wr_accept;
  logic                 mem_we;
  logic [SUMW-1:0]      last_word;
  logic                 unused_addr_lsbs;

  assign offset           = address_data_in[ADDR_BITS+1:2];
  assign hit              = address_data_in[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2];
  assign last_word        = SUMW'(offset) + SUMW'(burst_size_in);
  assign overrun          = last_word > SUMW'(DEPTH - 1);
  assign addr_next        = addr + ADDR_BITS'(1);
  assign wr_accept        = (state == WR_BURST) && data_valid_in && !busy_out;
  assign mem_we           = wr_accept && (words_left != 9'd0) && !reset;
  assign unused_addr_lsbs = ^address_data_in[1:0];

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enables_in[b]) mem[addr][8*b +: 8] <= address_data_in[8*b +: 8];
      end
    end
  end

  // words_left holds remaining reads after the current word, or remaining writes to accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      address_data_out    <= 32'h0;
      data_valid_out      <= 1'b0;
      end_transaction_out <= 1'b0;
      error_out           <= 1'b0;
      addr                <= '0;
      words_left          <= 9'd0;
      wait_cnt            <= 4'd0;
      wr_err_done         <= 1'b0;
    end else begin
      end_transaction_out <= 1'b0;
      error_out           <= 1'b0;
      case (state)
        IDLE: begin
          data_valid_out <= 1'b0;
          if (begin_transaction_in && hit) begin
            addr        <= offset;
            wr_err_done <= 1'b0;
            if (overrun) begin
              state     <= ERR;
              error_out <= 1'b1;
            end else if (read_n_write_in) begin
              state      <= RD_WAIT;
              words_left <= 9'(burst_size_in);
              wait_cnt   <= 4'(READ_LATENCY - 1);
            end else begin
              state      <= WR_BURST;
              words_left <= 9'(burst_size_in) + 9'd1;
            end
          end
        end
        RD_WAIT: begin
          if (end_transaction_in) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            state            <= RD_BURST;
            data_valid_out   <= 1'b1;
            address_data_out <= mem[addr];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RD_BURST: begin
          if (end_transaction_in) begin
            state            <= IDLE;
            data_valid_out   <= 1'b0;
            address_data_out <= 32'h0;
          end else if (!busy_in) begin
            if (words_left == 9'd0) begin
              state               <= IDLE;
              data_valid_out      <= 1'b0;
              address_data_out    <= 32'h0;
              end_transaction_out <= 1'b1;
            end else begin
              addr             <= addr_next;
              address_data_out <= mem[addr_next];
              words_left       <= words_left - 9'd1;
            end
          end
        end
        WR_BURST: begin
          if (wr_accept) begin
            if (words_left != 9'd0) begin
              addr       <= addr_next;
              words_left <= words_left - 9'd1;
            end else if (!wr_err_done) begin
              error_out   <= 1'b1;
              wr_err_done <= 1'b1;
            end
          end
          if (end_transaction_in) state <= IDLE;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_RESPONDER_STALL_EN
  logic [1:0] accept_cnt;

  // One stall cycle after every fourth word actually written in a transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_out   <= 1'b0;
      accept_cnt <= 2'd0;
    end else begin
      busy_out <= 1'b0;
      if (state == IDLE && begin_transaction_in && hit) begin
        accept_cnt <= 2'd0;
      end else if (mem_we) begin
        accept_cnt <= accept_cnt + 2'd1;
        if (accept_cnt == 2'd3) busy_out <= 1'b1;
      end
    end
  end
`else
  assign busy_out = 1'b0;
`endif

endmodule

// File: tb/tb_bus_burst_responder.sv
// Self-checking bench for bus_burst_responder: a memory model feeds a queue of expected
// read words, which is drained as the responder returns data.
module tb_bus_burst_responder;

  localparam int LAT = 2;
`ifdef BUS_RESPONDER_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        begin_transaction_in;
  logic        end_transaction_in;
  logic        read_n_write_in;
  logic [31:0] address_data_in;
  logic [7:0]  burst_size_in;
  logic [3:0]  byte_enables_in;
  logic        data_valid_in;
  logic        busy_in;
  logic [31:0] address_data_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic        busy_out;
  logic        error_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem[int];

  bus_burst_responder #(
    .BASE_ADDRESS(32'h5000_0000),
    .ADDR_BITS(10),
    .READ_LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .begin_transaction_in(begin_transaction_in),
    .end_transaction_in(end_transaction_in),
    .read_n_write_in(read_n_write_in),
    .address_data_in(address_data_in),
    .burst_size_in(burst_size_in),
    .byte_enables_in(byte_enables_in),
    .data_valid_in(data_valid_in),
    .busy_in(busy_in),
    .address_data_out(address_data_out),
    .data_valid_out(data_valid_out),
    .end_transaction_out(end_transaction_out),
    .busy_out(busy_out),
    .error_out(error_out)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    begin_transaction_in = 1'b0;
    end_transaction_in   = 1'b0;
    read_n_write_in      = 1'b0;
    address_data_in      = 32'h0;
    burst_size_in        = 8'h0;
    byte_enables_in      = 4'h0;
    data_valid_in        = 1'b0;
    busy_in              = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    vectors++;
    if ({data_valid_out, end_transaction_out, error_out, busy_out} !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL %s: dv/end/err/busy = %b, expected 0000", name,
               {data_valid_out, end_transaction_out, error_out, busy_out});
    end
  endtask

  // Write burst of nw words plus `extra` surplus words; end is raised with the final word.
  task automatic wr_burst(input string name, input logic [31:0] a, input int nw, input int extra,
                          input logic [3:0] be, input logic [31:0] d0);
    int          off;
    int          k;
    int          total;
    int          errs;
    int          budget;
    logic        acc;
    logic [31:0] w;
    logic        exp_busy;
    off    = int'((a >> 2) & 32'h3FF);
    total  = nw + extra;
    k      = 0;
    errs   = 0;
    budget = 0;
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b0;
    address_data_in      = a;
    burst_size_in        = 8'(nw - 1);
    tick();
    begin_transaction_in = 1'b0;
    while (k < total && budget < 4 * total + 8) begin
      data_valid_in      = 1'b1;
      address_data_in    = d0 + 32'(k);
      byte_enables_in    = be;
      acc                = !busy_out;
      end_transaction_in = (k == total - 1) && acc;
      tick();
      budget++;
      if (error_out === 1'b1) errs++;
      if (acc) begin
        if (k < nw) begin
          w = model_mem.exists(off + k) ? model_mem[off + k] : 32'h0;
          for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = (d0 + 32'(k)) >> (8 * b);
          model_mem[off + k] = w;
          k++;
          exp_busy = STALL_EN && (k % 4 == 0);
          vectors++;
          if (busy_out !== exp_busy) begin
            miscompares++;
            $display("[TB] FAIL %s busy after word %0d: got %b, expected %b", name, k, busy_out, exp_busy);
          end
        end else begin
          k++;
        end
      end
    end
    data_valid_in      = 1'b0;
    end_transaction_in = 1'b0;
    if (k < total) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s write timeout: accepted %0d, expected %0d", name, k, total);
    end
    tick();
    if (error_out === 1'b1) errs++;
    vectors++;
    if (errs != ((extra > 0) ? 1 : 0)) begin
      miscompares++;
      $display("[TB] FAIL %s error pulses: got %0d, expected %0d", name, errs, (extra > 0) ? 1 : 0);
    end
  endtask

  // Read burst; busy_mask bit j stalls the j-th data-valid cycle.
  task automatic rd_burst(input string name, input logic [31:0] a, input int nw, input logic [31:0] busy_mask);
    int off;
    int cyc;
    int vcount;
    int busies;
    bit first;
    off = int'((a >> 2) & 32'h3FF);
    for (int i = 0; i < nw; i++) exp_q.push_back(model_mem[off + i]);
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b1;
    address_data_in      = a;
    burst_size_in        = 8'(nw - 1);
    tick();
    begin_transaction_in = 1'b0;
    cyc    = 0;
    vcount = 0;
    busies = 0;
    first  = 1'b1;
    while (exp_q.size() > 0 && cyc < 64) begin
      tick();
      cyc++;
      busy_in = 1'b0;
      if (data_valid_out === 1'b1) begin
        if (first) begin
          first = 1'b0;
          vectors++;
          if (cyc != LAT) begin
            miscompares++;
            $display("[TB] FAIL %s first-data latency: got %0d, expected %0d", name, cyc, LAT);
          end
        end
        vectors++;
        if (address_data_out !== exp_q[0]) begin
          miscompares++;
          $display("[TB] FAIL %s data[%0d]: got %h, expected %h", name, vcount, address_data_out, exp_q[0]);
        end
        if (vcount < 32 && busy_mask[vcount]) begin
          busy_in = 1'b1;
          busies++;
        end else begin
          void'(exp_q.pop_front());
        end
        vcount++;
      end
    end
    busy_in = 1'b0;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s read timeout: %0d words outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
      return;
    end
    tick();
    vectors++;
    if ({end_transaction_out, data_valid_out} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL %s end pulse: end/dv = %b, expected 10", name, {end_transaction_out, data_valid_out});
    end
    tick();
    vectors++;
    if (end_transaction_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s end width: got %b, expected 0", name, end_transaction_out);
    end
    vectors++;
    if (vcount != nw + busies) begin
      miscompares++;
      $display("[TB] FAIL %s valid cycles: got %0d, expected %0d", name, vcount, nw + busies);
    end
  endtask

  task automatic wait_for_valid(input string name, input int words);
    int seen;
    int budget;
    seen   = 0;
    budget = 0;
    while (seen < words && budget < 32) begin
      tick();
      budget++;
      if (data_valid_out === 1'b1) seen++;
    end
    if (seen < words) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s wait: saw %0d valid words, expected %0d", name, seen, words);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    check_quiet("reset_ctrl");
    vectors++;
    if (address_data_out !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h, expected 00000000", address_data_out);
    end
    reset = 1'b0;
    tick();
    check_quiet("post_reset");
  endtask

  task automatic test_write_read();
    wr_burst("wr4", 32'h5000_0010, 4, 0, 4'hF, 32'd1);
    rd_burst("rd4", 32'h5000_0010, 4, 32'h0);
    rd_burst("rd4_busy", 32'h5000_0010, 4, 32'h2);
    rd_burst("rd_single", 32'h5000_0014, 1, 32'h0);
  endtask

  task automatic test_overrun();
    wr_burst("wr_top", 32'h5000_0FF0, 4, 0, 4'hF, 32'hCAFE_0000);
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b0;
    address_data_in      = 32'h5000_0FF8;
    burst_size_in        = 8'd2;
    tick();
    begin_transaction_in = 1'b0;
    vectors++;
    if ({error_out, data_valid_out} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL overrun_wr error: err/dv = %b, expected 10", {error_out, data_valid_out});
    end
    for (int i = 0; i < 3; i++) begin
      data_valid_in      = 1'b1;
      address_data_in    = 32'hBAD0_0000 + 32'(i);
      byte_enables_in    = 4'hF;
      end_transaction_in = (i == 2);
      tick();
      check_quiet("overrun_wr_after");
    end
    idle_inputs();
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b1;
    address_data_in      = 32'h5000_0FFC;
    burst_size_in        = 8'd1;
    tick();
    begin_transaction_in = 1'b0;
    vectors++;
    if (error_out !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overrun_rd error: got %b, expected 1", error_out);
    end
    repeat (LAT + 1) begin
      tick();
      check_quiet("overrun_rd_after");
    end
    rd_burst("top_unchanged", 32'h5000_0FF3, 4, 32'h0);
  endtask

  task automatic test_miss_and_partial();
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b1;
    address_data_in      = 32'h4000_0000;
    burst_size_in        = 8'd3;
    tick();
    begin_transaction_in = 1'b0;
    repeat (6) begin
      tick();
      check_quiet("miss_rd");
    end
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b0;
    address_data_in      = 32'h4000_0010;
    tick();
    begin_transaction_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_valid_in      = 1'b1;
      address_data_in    = 32'hDEAD_0000 + 32'(i);
      byte_enables_in    = 4'hF;
      end_transaction_in = (i == 3);
      tick();
      check_quiet("miss_wr");
    end
    idle_inputs();
    tick();
    rd_burst("miss_no_write", 32'h5000_0010, 4, 32'h0);
    wr_burst("fill_1111", 32'h5000_0050, 1, 0, 4'hF, 32'h1111_1111);
    wr_burst("partial", 32'h5000_0050, 1, 0, 4'b0011, 32'hAABB_CCDD);
    wr_burst("partial_hi", 32'h5000_0054, 1, 0, 4'hF, 32'h2222_2222);
    wr_burst("partial_hi2", 32'h5000_0054, 1, 0, 4'b1100, 32'h9988_7766);
    rd_burst("partial_rd", 32'h5000_0050, 2, 32'h0);
  endtask

  task automatic test_write_overflow();
    wr_burst("ovf_fill", 32'h5000_0100, 3, 0, 4'hF, 32'h0000_0100);
    wr_burst("ovf_extra", 32'h5000_0100, 1, 2, 4'hF, 32'h0000_7700);
    rd_burst("ovf_rd", 32'h5000_0100, 3, 32'h0);
  endtask

  task automatic test_abort();
    wr_burst("abort_fill", 32'h5000_0200, 8, 0, 4'hF, 32'h0000_0200);
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b1;
    address_data_in      = 32'h5000_0200;
    burst_size_in        = 8'd7;
    tick();
    begin_transaction_in = 1'b0;
    wait_for_valid("abort_burst", 2);
    end_transaction_in = 1'b1;
    tick();
    end_transaction_in = 1'b0;
    check_quiet("abort_burst");
    tick();
    check_quiet("abort_burst_idle");
    begin_transaction_in = 1'b1;
    address_data_in      = 32'h5000_0200;
    burst_size_in        = 8'd3;
    tick();
    begin_transaction_in = 1'b0;
    end_transaction_in   = 1'b1;
    tick();
    end_transaction_in = 1'b0;
    repeat (LAT + 2) begin
      tick();
      check_quiet("abort_wait");
    end
    rd_burst("after_abort", 32'h5000_0208, 3, 32'h0);
  endtask

  task automatic test_reset_mid_read();
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b1;
    address_data_in      = 32'h5000_0200;
    burst_size_in        = 8'd7;
    tick();
    begin_transaction_in = 1'b0;
    wait_for_valid("reset_mid", 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_quiet("reset_mid_ctrl");
    vectors++;
    if (address_data_out !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_data: got %h, expected 00000000", address_data_out);
    end
    rd_burst("after_reset", 32'h5000_0204, 4, 32'h5);
  endtask

  task automatic test_stall_feature();
    wr_burst("wr8", 32'h5000_0300, 8, 0, 4'hF, 32'h0000_0300);
    rd_burst("rd8", 32'h5000_0300, 8, 32'h0);
  endtask

  task automatic test_back_to_back();
    wr_burst("b2b_wr", 32'h5000_0000, 2, 0, 4'hF, 32'h5A5A_0000);
    wr_burst("b2b_wr2", 32'h5000_0008, 2, 0, 4'hF, 32'hA5A5_0000);
    rd_burst("b2b_rd", 32'h5000_0000, 4, 32'h9);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_overrun();
    test_miss_and_partial();
    test_write_overflow();
    test_abort();
    test_reset_mid_read();
    test_stall_feature();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
